// File: rtl/axis_pixel_op_engine.sv
// AXI4-Stream per-lane pixel operator (pass / invert / threshold / saturating add)
// with a one-beat output register and an AXI4-Lite control/status register file.
module axis_pixel_op_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int CHAN_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  axi_clk,
  input  logic                  axi_reset,
  input  logic                  s_axis_valid,
  input  logic [DATA_WIDTH-1:0] s_axis_data,
  output logic                  s_axis_ready,
  output logic                  m_axis_valid,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  input  logic                  m_axis_ready,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int LANES = DATA_WIDTH / CHAN_WIDTH;
  localparam int WKEEP = (CHAN_WIDTH > 4) ? CHAN_WIDTH : 4;
  localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL  = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_PARAM = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ADDR_BEATS = ADDR_WIDTH'(8);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ID    = ADDR_WIDTH'(12);
  localparam logic [31:0]           ID_VALUE   = 32'h434F4E31;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_INV  = 2'd1,
    MODE_THR  = 2'd2,
    MODE_ADD  = 2'd3
  } op_mode_e;

  logic                  enable_q;
  op_mode_e              mode_q;
  logic [CHAN_WIDTH-1:0] param_q;
  logic [31:0]           beats_q;

  logic                  m_valid_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic [DATA_WIDTH-1:0] m_data_d;

  logic                  aw_full_q;
  logic                  w_full_q;
  logic                  bvalid_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [WKEEP-1:0]      wdata_q;

  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;

  logic accept, out_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, do_write;
  logic unused_wdata;

  // Only the low bits of a write carry register content.
  assign unused_wdata = ^s_axi_wdata[DATA_WIDTH-1:WKEEP];

  // ---------------- stream path ----------------
  assign s_axis_ready = enable_q & (~m_valid_q | m_axis_ready);
  assign accept       = s_axis_valid & s_axis_ready;
  assign out_hs       = m_valid_q & m_axis_ready;
  assign m_axis_valid = m_valid_q;
  assign m_axis_data  = m_data_q;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [CHAN_WIDTH-1:0] x;
    logic [CHAN_WIDTH-1:0] y;
    logic [CHAN_WIDTH:0]   sum;
    assign x   = s_axis_data[gi*CHAN_WIDTH +: CHAN_WIDTH];
    assign sum = {1'b0, x} + {1'b0, param_q};
    assign y   = (mode_q == MODE_INV) ? ~x :
                 (mode_q == MODE_THR) ? {CHAN_WIDTH{x >= param_q}} :
                 (mode_q == MODE_ADD) ? (sum[CHAN_WIDTH] ? {CHAN_WIDTH{1'b1}} : sum[CHAN_WIDTH-1:0]) :
                 x;
    assign m_data_d[gi*CHAN_WIDTH +: CHAN_WIDTH] = y;
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else if (accept) begin
      m_valid_q <= 1'b1;
      m_data_q  <= m_data_d;
    end else if (out_hs) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end
  end

  // ---------------- AXI-Lite write ----------------
  assign aw_hs    = s_axi_awvalid & ~aw_full_q;
  assign w_hs     = s_axi_wvalid & ~w_full_q;
  assign b_hs     = bvalid_q & s_axi_bready;
  assign do_write = aw_full_q & w_full_q & ~bvalid_q;

  assign s_axi_awready = ~aw_full_q;
  assign s_axi_wready  = ~w_full_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = 2'b00;

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
    end else begin
      if (aw_hs) begin
        aw_full_q <= 1'b1;
        awaddr_q  <= s_axi_awaddr;
      end
      if (w_hs) begin
        w_full_q <= 1'b1;
        wdata_q  <= s_axi_wdata[WKEEP-1:0];
      end
      if (do_write) bvalid_q <= 1'b1;
      // Both channels stay stalled until the response is taken.
      if (b_hs) begin
        bvalid_q  <= 1'b0;
        aw_full_q <= 1'b0;
        w_full_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      enable_q <= 1'b0;
      mode_q   <= MODE_PASS;
      param_q  <= '0;
      beats_q  <= '0;
    end else begin
      if (do_write && awaddr_q == ADDR_CTRL) begin
        enable_q <= wdata_q[0];
        mode_q   <= op_mode_e'(wdata_q[2:1]);
      end
      if (do_write && awaddr_q == ADDR_PARAM) param_q <= wdata_q[CHAN_WIDTH-1:0];
      // A clear landing on the same edge as a handshake takes priority.
      if (do_write && awaddr_q == ADDR_CTRL && wdata_q[3]) beats_q <= '0;
      else if (out_hs)                                     beats_q <= beats_q + 32'd1;
    end
  end

  // ---------------- AXI-Lite read ----------------
  assign ar_hs = s_axi_arvalid & ~rvalid_q;
  assign r_hs  = rvalid_q & s_axi_rready;

  assign s_axi_arready = ~rvalid_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = 2'b00;

  always_comb begin
    rdata_d = '0;
    case (s_axi_araddr)
      ADDR_CTRL:  rdata_d = DATA_WIDTH'({mode_q, enable_q});
      ADDR_PARAM: rdata_d = DATA_WIDTH'(param_q);
      ADDR_BEATS: rdata_d = DATA_WIDTH'(beats_q);
      ADDR_ID:    rdata_d = DATA_WIDTH'(ID_VALUE);
      default:    rdata_d = '0;
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rdata_d;
    end else if (r_hs) begin
      rvalid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_pixel_op_engine.sv
// Directed bench for axis_pixel_op_engine: a lane-arithmetic model and a scoreboard
// check every output handshake; register reads and literals pin the model.
module tb_axis_pixel_op_engine;

  logic        clk, rst;
  logic        s_valid, s_ready, m_valid, m_ready;
  logic [31:0] s_data, m_data;
  logic [3:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [1:0]  bresp, rresp;

  int n_cmp = 0;
  int n_bad = 0;

  bit          model_en    = 0;
  int          model_mode  = 0;
  int          model_param = 0;
  int          model_beats = 0;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  bit          prev_stall = 0;
  logic [31:0] prev_data;

  axis_pixel_op_engine #(.DATA_WIDTH(32), .CHAN_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .axi_clk(clk), .axi_reset(rst),
    .s_axis_valid(s_valid), .s_axis_data(s_data), .s_axis_ready(s_ready),
    .m_axis_valid(m_valid), .m_axis_data(m_data), .m_axis_ready(m_ready),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_op(input logic [31:0] x, input int mode, input int p);
    logic [31:0] r;
    int v, o;
    r = '0;
    for (int l = 0; l < 4; l++) begin
      v = int'((x >> (8*l)) & 32'hFF);
      case (mode)
        0:       o = v;
        1:       o = 255 - v;
        2:       o = (v >= p) ? 255 : 0;
        default: o = (v + p > 255) ? 255 : v + p;
      endcase
      r[8*l +: 8] = o[7:0];
    end
    return r;
  endfunction

  // Scoreboard: every accepted beat predicts one output, checked at its handshake.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 0;
    end else begin
      if (!bvalid) chk("s_ready", {31'd0, s_ready}, {31'd0, model_en && (!m_valid || m_ready)});
      if (prev_stall) begin
        chk("stall_valid", {31'd0, m_valid}, 32'd1);
        chk("stall_data", m_data, prev_data);
      end
      if (s_valid && s_ready) exp_q.push_back(model_op(s_data, model_mode, model_param));
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
        else                   chk("out_data", m_data, exp_q.pop_front());
        obs_q.push_back(m_data);
        model_beats++;
        $display("beat out %h (beats model %0d)", m_data, model_beats);
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic axil_write(input logic [3:0] a, input logic [31:0] d, input int w_lead,
                            input int b_hold, input bit rel_out, input bit finish_b);
    int n;
    @(posedge clk); #1;
    wvalid = 1; wdata = d;
    if (w_lead == 0) begin awvalid = 1; awaddr = a; end
    @(negedge clk);
    chk("wready_idle", {31'd0, wready}, 32'd1);
    @(posedge clk); #1;
    wvalid = 0;
    if (w_lead > 0) begin
      repeat (w_lead - 1) begin
        @(negedge clk);
        chk("bvalid_w_only", {31'd0, bvalid}, 32'd0);
        chk("wready_latched", {31'd0, wready}, 32'd0);
        @(posedge clk); #1;
      end
      awvalid = 1; awaddr = a;
      @(negedge clk);
      chk("awready_idle", {31'd0, awready}, 32'd1);
      @(posedge clk); #1;
    end
    awvalid = 0;
    if (rel_out) m_ready = 1;
    n = 0;
    @(negedge clk);
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    chk("bvalid_seen", {31'd0, bvalid}, 32'd1);
    chk("bresp", {30'd0, bresp}, 32'd0);
    if (a == 4'h0) begin
      model_en = d[0]; model_mode = int'(d[2:1]);
      if (d[3]) model_beats = 0;
    end else if (a == 4'h4) model_param = int'(d[7:0]);
    $display("axil write [%h] <= %h", a, d);
    if (!finish_b) return;
    repeat (b_hold) begin
      @(negedge clk);
      chk("bvalid_hold", {31'd0, bvalid}, 32'd1);
    end
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    @(negedge clk);
    chk("bvalid_done", {31'd0, bvalid}, 32'd0);
    chk("awready_back", {31'd0, awready}, 32'd1);
    chk("wready_back", {31'd0, wready}, 32'd1);
  endtask

  task automatic axil_read(input logic [3:0] a, input int r_hold, output logic [31:0] d);
    int n;
    @(posedge clk); #1;
    arvalid = 1; araddr = a;
    @(negedge clk);
    chk("arready_idle", {31'd0, arready}, 32'd1);
    @(posedge clk); #1;
    arvalid = 0;
    n = 0;
    @(negedge clk);
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    chk("rvalid_seen", {31'd0, rvalid}, 32'd1);
    chk("arready_busy", {31'd0, arready}, 32'd0);
    chk("rresp", {30'd0, rresp}, 32'd0);
    d = rdata;
    repeat (r_hold) begin
      @(negedge clk);
      chk("rdata_hold", rdata, d);
    end
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
    @(negedge clk);
    chk("rvalid_done", {31'd0, rvalid}, 32'd0);
    chk("arready_back", {31'd0, arready}, 32'd1);
    $display("axil read  [%h] -> %h", a, d);
  endtask

  task automatic send_one(input logic [31:0] d, input logic [31:0] exp, input bit check_out);
    int n;
    @(posedge clk); #1;
    s_valid = 1; s_data = d;
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 20) begin @(negedge clk); n++; end
    chk("s_accept", {31'd0, s_ready}, 32'd1);
    @(posedge clk); #1;
    s_valid = 0;
    if (check_out) begin
      @(negedge clk);
      chk("lit_valid", {31'd0, m_valid}, 32'd1);
      chk("lit_data", m_data, exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int idx, cyc;
    rst = 1; s_valid = 0; s_data = 0; m_ready = 0;
    awaddr = 0; awvalid = 0; wdata = 0; wvalid = 0; bready = 0;
    araddr = 0; arvalid = 0; rready = 0;

    chk("model_pin_inv", model_op(32'h00FF107F, 1, 0), 32'hFF00EF80);
    chk("model_pin_add", model_op(32'hF0E01020, 3, 32'h20), 32'hFFFF3040);

    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_data", m_data, 32'd0);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_awready", {31'd0, awready}, 32'd1);
    chk("rst_wready", {31'd0, wready}, 32'd1);
    chk("rst_arready", {31'd0, arready}, 32'd1);
    chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);

    // 1: ID and CTRL after reset
    axil_read(4'hC, 2, rd); chk("rd_id", rd, 32'h434F4E31);
    axil_read(4'h0, 0, rd); chk("rd_ctrl_rst", rd, 32'h0);
    axil_read(4'h8, 0, rd); chk("rd_beats_rst", rd, 32'h0);

    // PARAM keeps only its lane-width field
    axil_write(4'h4, 32'hABCD1280, 0, 0, 0, 1);
    axil_read(4'h4, 0, rd); chk("rd_param_trunc", rd, 32'h80);

    // 2: invert
    m_ready = 1;
    axil_write(4'h0, 32'h3, 0, 0, 0, 1);
    send_one(32'h00FF107F, 32'hFF00EF80, 1);

    // 3: threshold then saturating add
    axil_write(4'h4, 32'h80, 0, 0, 0, 1);
    axil_write(4'h0, 32'h5, 0, 0, 0, 1);
    send_one(32'h7F80FF00, 32'h00FFFF00, 1);
    axil_write(4'h0, 32'h7, 0, 0, 0, 1);
    axil_write(4'h4, 32'h20, 0, 0, 0, 1);
    send_one(32'hF0E01020, 32'hFFFF3040, 1);

    // 4: pass-through burst under backpressure, counter cleared first
    axil_write(4'h0, 32'h9, 0, 0, 0, 1);
    axil_read(4'h8, 0, rd); chk("rd_beats_cleared", rd, 32'd0);
    obs_q.delete();
    idx = 0; cyc = 0;
    while ((idx < 8 || exp_q.size() != 0) && cyc < 200) begin
      @(posedge clk); #1;
      m_ready = (cyc % 3 == 0);
      if (idx < 8) begin s_valid = 1; s_data = idx + 1; end
      else s_valid = 0;
      @(negedge clk);
      if (s_valid && s_ready) idx++;
      cyc++;
    end
    s_valid = 0; m_ready = 1;
    @(negedge clk);
    chk("burst_drained", exp_q.size(), 32'd0);
    chk("burst_count", obs_q.size(), 32'd8);
    for (int i = 0; i < obs_q.size() && i < 8; i++) chk("burst_order", obs_q[i], i + 1);
    axil_read(4'h8, 0, rd);
    chk("rd_beats_8", rd, 32'd8);
    chk("rd_beats_model", rd, model_beats);

    // 5: W leads AW by 3 cycles, slow bready, clear coincides with a handshake
    m_ready = 0;
    send_one(32'hA5A5A5A5, 32'h0, 0);
    axil_write(4'h0, 32'h9, 3, 4, 1, 1);
    axil_read(4'h8, 0, rd);
    chk("rd_beats_clear_wins", rd, 32'd0);
    chk("rd_beats_model2", rd, model_beats);
    axil_read(4'h0, 0, rd); chk("rd_ctrl_after", rd, 32'h1);

    // 6: reset with an output beat and a write response both pending
    m_ready = 0;
    send_one(32'h01020304, 32'h0, 0);
    axil_write(4'h4, 32'h11, 0, 0, 0, 0);
    @(negedge clk);
    chk("pre_rst_m_valid", {31'd0, m_valid}, 32'd1);
    chk("pre_rst_bvalid", {31'd0, bvalid}, 32'd1);
    @(posedge clk); #1;
    rst = 1;
    model_en = 0; model_mode = 0; model_param = 0; model_beats = 0;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("mid_rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("mid_rst_bvalid", {31'd0, bvalid}, 32'd0);
    chk("mid_rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("mid_rst_awready", {31'd0, awready}, 32'd1);
    axil_read(4'h0, 0, rd); chk("rd_ctrl_mid_rst", rd, 32'h0);
    axil_read(4'h4, 0, rd); chk("rd_param_mid_rst", rd, 32'h0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
